tt_vfp_fma_seq: RTL and testbench

- Request-side sequencer for the 2-stage recoded-format FP FMA unit (tt_vfp_fma).
- Accepts one packed vector FMA request per transaction.
- Recodes standard-format elements to HardFloat recoded format and issues them one per cycle to the FMA.
- Tracks in-flight lanes through the FMA's fixed latency, captures results and exceptions, and returns a packed result vector plus OR-accumulated fflags on a valid/ready response channel.

---
 rtl/tt_vfp_fma_seq.sv | 167 ++++++++++++++++
 tb/tb_tt_vfp_fma_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_vfp_fma_seq.sv
// rtl/tt_vfp_fma_seq.sv - Request sequencer feeding a fixed-latency recoded-format FMA.
// Optional: define TT_VFP_FMA_SEQ_COMPACT_EN to issue only the active lanes.
module tt_vfp_fma_seq #(
    parameter int EXP_W    = 5,
    parameter int SIG_W    = 11,
    parameter int NUM_ELEM = 4,
    parameter int FMA_LAT  = 1
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_req_valid,
    output logic                                o_req_ready,
    input  logic [1:0]                          i_req_op,
    input  logic [2:0]                          i_req_rm,
    input  logic [NUM_ELEM-1:0]                 i_req_mask,
    input  logic [NUM_ELEM*(EXP_W+SIG_W)-1:0]   i_req_a,
    input  logic [NUM_ELEM*(EXP_W+SIG_W)-1:0]   i_req_b,
    input  logic [NUM_ELEM*(EXP_W+SIG_W)-1:0]   i_req_c,
    output logic                                o_fma_valid,
    output logic [1:0]                          o_fma_op,
    output logic [2:0]                          o_fma_rm,
    output logic [EXP_W+SIG_W:0]                o_fma_a,
    output logic [EXP_W+SIG_W:0]                o_fma_b,
    output logic [EXP_W+SIG_W:0]                o_fma_c,
    input  logic [EXP_W+SIG_W-1:0]              i_fma_res,
    input  logic [4:0]                          i_fma_exc,
    output logic                                o_rsp_valid,
    input  logic                                i_rsp_ready,
    output logic [NUM_ELEM*(EXP_W+SIG_W)-1:0]   o_rsp_data,
    output logic [4:0]                          o_rsp_fflags
);
    localparam int FLEN   = EXP_W + SIG_W;
    localparam int LANE_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int CNT_W  = $clog2(FMA_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

    state_t                      r_state, w_state_nxt;
    logic [1:0]                  r_op;
    logic [2:0]                  r_rm;
    logic [NUM_ELEM-1:0]         r_mask;
    logic [NUM_ELEM*FLEN-1:0]    r_a, r_b, r_c, r_res;
    logic [4:0]                  r_fflags;
    logic [LANE_W-1:0]           r_lane;
    logic [CNT_W-1:0]            r_drain_cnt;
    logic [FMA_LAT-1:0]          r_trk_v;
    logic [LANE_W-1:0]           r_trk_idx [FMA_LAT];
    logic [LANE_W-1:0]           w_lane_first, w_lane_next;
    logic                        w_last;

    // Standard to HardFloat recoded format (fNToRecFN); subnormals are normalised.
    function automatic logic [FLEN:0] f_rec(input logic [FLEN-1:0] x);
        logic [EXP_W-1:0] e_in;
        logic [SIG_W-2:0] f_in, sub_f;
        logic [SIG_W-1:0] shifted;
        logic [EXP_W:0]   norm_dist, adj_base, adj_off, adj, e_out;
        logic             zero_e, is_zero, is_special;
        e_in      = x[FLEN-2 -: EXP_W];
        f_in      = x[SIG_W-2:0];
        zero_e    = (e_in == '0);
        norm_dist = '0;
        for (int i = 0; i < SIG_W-1; i++) begin
            if (f_in[i]) norm_dist = (EXP_W+1)'(SIG_W - 2 - i);
        end
        shifted    = {f_in, 1'b0} << norm_dist;
        sub_f      = shifted[SIG_W-2:0];
        adj_base   = zero_e ? ~norm_dist : {1'b0, e_in};
        adj_off    = (EXP_W+1)'(1 << (EXP_W-1)) | (zero_e ? (EXP_W+1)'(2) : (EXP_W+1)'(1));
        adj        = adj_base + adj_off;
        is_zero    = zero_e && (f_in == '0);
        is_special = (adj[EXP_W:EXP_W-1] == 2'b11);
        e_out      = adj;
        if (is_special)   e_out[EXP_W:EXP_W-2] = {2'b11, |f_in};
        else if (is_zero) e_out[EXP_W:EXP_W-2] = 3'b000;
        return {x[FLEN-1], e_out, zero_e ? sub_f : f_in};
    endfunction

`ifdef TT_VFP_FMA_SEQ_COMPACT_EN
    always_comb begin
        w_lane_first = '0;
        w_lane_next  = r_lane;
        w_last       = 1'b1;
        for (int i = NUM_ELEM-1; i >= 0; i--) begin
            if (i_req_mask[i]) w_lane_first = LANE_W'(i);
            if (r_mask[i] && (i > int'(r_lane))) begin
                w_lane_next = LANE_W'(i);
                w_last      = 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_lane_first = '0;
        w_lane_next  = r_lane + LANE_W'(1);
        w_last       = (r_lane == LANE_W'(NUM_ELEM-1));
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_req_valid) w_state_nxt = (i_req_mask == '0) ? S_RESP : S_ISSUE;
            S_ISSUE: if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == CNT_W'(FMA_LAT-1)) w_state_nxt = S_RESP;
            S_RESP:  if (i_rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_fma_valid  = (r_state == S_ISSUE) && r_mask[r_lane];
    assign o_fma_op     = r_op;
    assign o_fma_rm     = r_rm;
    assign o_fma_a      = f_rec(r_a[r_lane*FLEN +: FLEN]);
    assign o_fma_b      = f_rec(r_b[r_lane*FLEN +: FLEN]);
    assign o_fma_c      = f_rec(r_c[r_lane*FLEN +: FLEN]);
    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_rsp_data   = r_res;
    assign o_rsp_fflags = r_fflags;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_rm        <= '0;
            r_mask      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_fflags    <= '0;
            r_lane      <= '0;
            r_drain_cnt <= '0;
            r_trk_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Tracking pipe tags each FMA slot with its lane so results land by index.
            for (int i = FMA_LAT-1; i > 0; i--) begin
                r_trk_v[i]   <= r_trk_v[i-1];
                r_trk_idx[i] <= r_trk_idx[i-1];
            end
            r_trk_v[0]   <= o_fma_valid;
            r_trk_idx[0] <= r_lane;
            if (r_trk_v[FMA_LAT-1]) begin
                r_res[r_trk_idx[FMA_LAT-1]*FLEN +: FLEN] <= i_fma_res;
                r_fflags <= r_fflags | i_fma_exc;
            end
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_op        <= i_req_op;
                    r_rm        <= i_req_rm;
                    r_mask      <= i_req_mask;
                    r_a         <= i_req_a;
                    r_b         <= i_req_b;
                    r_c         <= i_req_c;
                    r_res       <= i_req_c;
                    r_fflags    <= '0;
                    r_lane      <= w_lane_first;
                    r_drain_cnt <= '0;
                end
                S_ISSUE: r_lane <= w_lane_next;
                S_DRAIN: r_drain_cnt <= r_drain_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_vfp_fma_seq.sv
// tb/tb_tt_vfp_fma_seq.sv - Self-checking bench for tt_vfp_fma_seq with an exact-arithmetic FP16 FMA stand-in.
module tb_tt_vfp_fma_seq;
    localparam int NE  = 4;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, fma_valid, rsp_valid, rsp_ready;
    logic [1:0]  req_op, fma_op;
    logic [2:0]  req_rm, fma_rm;
    logic [3:0]  req_mask;
    logic [63:0] req_a, req_b, req_c, rsp_data;
    logic [16:0] fma_a, fma_b, fma_c;
    logic [15:0] fma_res;
    logic [4:0]  fma_exc, rsp_fflags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tt_vfp_fma_seq #(.EXP_W(5), .SIG_W(11), .NUM_ELEM(NE), .FMA_LAT(LAT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_rm(req_rm), .i_req_mask(req_mask),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_c(req_c),
        .o_fma_valid(fma_valid), .o_fma_op(fma_op), .o_fma_rm(fma_rm),
        .o_fma_a(fma_a), .o_fma_b(fma_b), .o_fma_c(fma_c),
        .i_fma_res(fma_res), .i_fma_exc(fma_exc),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_fflags(rsp_fflags)
    );

    // Operand as value = sig * 2^e, plus class: 0 finite, 1 inf, 2 NaN.
    typedef struct {
        int cls;
        bit sign;
        bit snan;
        int sig;
        int e;
    } num_t;

    function automatic num_t dec_std(input logic [15:0] x);
        num_t n;
        n.sign = x[15]; n.snan = 1'b0; n.cls = 0; n.sig = 0; n.e = 0;
        if (x[14:10] == 5'h1f) begin
            n.cls  = (x[9:0] == 0) ? 1 : 2;
            n.snan = (x[9:0] != 0) && !x[9];
        end else if (x[14:10] == 0) begin
            n.sig = int'(x[9:0]); n.e = -24;
        end else begin
            n.sig = 1024 + int'(x[9:0]); n.e = int'(x[14:10]) - 25;
        end
        return n;
    endfunction

    function automatic num_t dec_rec(input logic [16:0] x);
        num_t n;
        n.sign = x[16]; n.snan = 1'b0; n.cls = 0; n.sig = 0; n.e = 0;
        case (x[15:13])
            3'b000: ;
            3'b110: n.cls = 1;
            3'b111: begin n.cls = 2; n.snan = !x[9]; end
            default: begin n.sig = 1024 + int'(x[9:0]); n.e = int'(x[15:10]) - 42; end
        endcase
        return n;
    endfunction

    // Exact fused a*b+c (values scaled by 2^72), rounded to FP16 nearest-even. Returns {fflags, result}.
    function automatic logic [20:0] fma_ref(input logic [1:0] op, input num_t a, input num_t b, input num_t c);
        logic         ps, cs, s, pinf, pzero, nx, uf;
        logic [127:0] p, cm, m, q, rem, half;
        int           msb, sh, bexp;
        ps    = a.sign ^ b.sign ^ op[1];
        cs    = c.sign ^ op[0];
        pinf  = (a.cls == 1) || (b.cls == 1);
        pzero = (a.cls == 0 && a.sig == 0) || (b.cls == 0 && b.sig == 0);
        if (a.cls == 2 || b.cls == 2 || c.cls == 2) return {a.snan | b.snan | c.snan, 4'b0, 16'h7e00};
        if (pinf && pzero) return {5'h10, 16'h7e00};
        if (pinf && c.cls == 1 && ps != cs) return {5'h10, 16'h7e00};
        if (pinf) return {5'h00, ps, 15'h7c00};
        if (c.cls == 1) return {5'h00, cs, 15'h7c00};
        p  = 128'(a.sig * b.sig) << (a.e + b.e + 72);
        cm = 128'(c.sig) << (c.e + 72);
        if (ps == cs)   begin m = p + cm; s = ps; end
        else if (p >= cm) begin m = p - cm; s = ps; end
        else            begin m = cm - p; s = cs; end
        if (m == 0) return {5'h00, (p == 0 && cm == 0) ? (ps & cs) : 1'b0, 15'h0000};
        msb = 0;
        for (int i = 0; i < 128; i++) if (m[i]) msb = i;
        sh   = (msb - 10 > 48) ? msb - 10 : 48;
        q    = m >> sh;
        rem  = m & ((128'd1 << sh) - 128'd1);
        half = 128'd1 << (sh - 1);
        nx   = (rem != 0);
        uf   = nx && (msb < 58);
        if (rem > half || (rem == half && q[0])) q = q + 128'd1;
        if (q == 128'd2048) begin q = 128'd1024; sh = sh + 1; end
        bexp = (q < 128'd1024) ? 0 : sh - 47;
        if (bexp >= 31) return {5'h05, s, 15'h7c00};
        return {3'b000, uf, nx, s, 5'(bexp), q[9:0]};
    endfunction

    function automatic logic [68:0] ref_rsp(input logic [1:0] op, input logic [3:0] mask,
                                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [63:0] d;
        logic [4:0]  ff;
        logic [20:0] r;
        d = c; ff = 5'h0;
        for (int k = 0; k < NE; k++) begin
            if (mask[k]) begin
                r = fma_ref(op, dec_std(a[k*16 +: 16]), dec_std(b[k*16 +: 16]), dec_std(c[k*16 +: 16]));
                d[k*16 +: 16] = r[15:0];
                ff = ff | r[20:16];
            end
        end
        return {ff, d};
    endfunction

    // FMA stand-in: decodes the recoded operands, answers LAT cycles later, garbage otherwise.
    logic [LAT-1:0] stub_v;
    logic [20:0]    stub_d [LAT];
    logic [20:0]    junk;
    always @(posedge clk) begin
        for (int i = LAT-1; i > 0; i--) begin
            stub_v[i] <= stub_v[i-1];
            stub_d[i] <= stub_d[i-1];
        end
        stub_v[0] <= fma_valid;
        stub_d[0] <= fma_ref(fma_op, dec_rec(fma_a), dec_rec(fma_b), dec_rec(fma_c));
        junk      <= 21'($urandom);
    end
    assign fma_res = stub_v[LAT-1] ? stub_d[LAT-1][15:0]  : junk[15:0];
    assign fma_exc = stub_v[LAT-1] ? stub_d[LAT-1][20:16] : junk[20:16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic [1:0] op, input logic [2:0] rm, input logic [3:0] mask,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input int hold,
                           input logic [63:0] exp_data, input logic [4:0] exp_ff);
        logic [63:0] iss_off, exp_off, d;
        logic [4:0]  ff;
        logic        op_ok, stable;
        int          lat, exp_lat;
        iss_off = '0; exp_off = '0; op_ok = 1'b1; stable = 1'b1; lat = -1;
`ifdef TT_VFP_FMA_SEQ_COMPACT_EN
        exp_lat = (mask == 0) ? 1 : $countones(mask) + LAT + 1;
        for (int j = 1; j <= $countones(mask); j++) exp_off[j] = 1'b1;
`else
        exp_lat = (mask == 0) ? 1 : NE + LAT + 1;
        for (int k = 0; k < NE; k++) if (mask[k]) exp_off[k+1] = 1'b1;
`endif
        req_op = op; req_rm = rm; req_mask = mask; req_a = a; req_b = b; req_c = c; req_valid = 1'b1;
        for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_c = {$urandom, $urandom};
        req_op = 2'($urandom); req_rm = 3'($urandom); req_mask = 4'($urandom);
        for (int k = 1; k < 64; k++) begin
            if (fma_valid) begin
                iss_off[k] = 1'b1;
                if (fma_op !== op || fma_rm !== rm) op_ok = 1'b0;
            end
            if (rsp_valid) begin lat = k; break; end
            @(negedge clk);
        end
        chk({tag, "_rsp_latency"}, 64'(lat), 64'(exp_lat));
        if (lat < 0) return;
        d = rsp_data; ff = rsp_fflags;
        chk({tag, "_rsp_data"}, d, exp_data);
        chk({tag, "_rsp_fflags"}, ff, exp_ff);
        chk({tag, "_issue_cycles"}, iss_off, exp_off);
        chk({tag, "_fma_op_rm"}, op_ok, 1'b1);
        chk({tag, "_ready_in_resp"}, req_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_data !== d || rsp_fflags !== ff || !rsp_valid || req_ready) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_backpressure_stable"}, stable, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_post_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_post_req_ready"}, req_ready, 1'b1);
    endtask

    function automatic logic [15:0] rnd_fp16();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
    endfunction

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [3:0]  mask;
        logic [63:0] a, b, c;
        int          hold;
        logic [63:0] exp_data;
        logic [4:0]  exp_ff;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        logic [63:0] a, b, c;
        logic [68:0] r;
        logic        saw;
        vecs[0] = '{"basic",   2'd0, 4'hF, 64'h3c00_3c00_3c00_3c00, 64'h4000_4000_4000_4000,
                    64'h4200_4200_4200_4200, 0, 64'h4500_4500_4500_4500, 5'h00};
        vecs[1] = '{"masked",  2'd0, 4'h5, 64'h3c00_3c00_3c00_3c00, 64'h4000_4000_4000_4000,
                    64'h1234_4200_1234_4200, 0, 64'h1234_4500_1234_4500, 5'h00};
        vecs[2] = '{"except",  2'd0, 4'hF, 64'h3c00_7bff_3c00_7c00, 64'h4000_4000_4000_0000,
                    64'h4200_0000_4200_4200, 0, 64'h4500_7c00_4500_7e00, 5'h15};
        vecs[3] = '{"allmask", 2'd0, 4'h0, 64'h3c00_3c00_3c00_3c00, 64'h4000_4000_4000_4000,
                    64'h1111_2222_3333_4444, 0, 64'h1111_2222_3333_4444, 5'h00};
        vecs[4] = '{"backpr",  2'd0, 4'hF, 64'h3c00_3c00_3c00_3c00, 64'h4000_4000_4000_4000,
                    64'h4200_4200_4200_4200, 5, 64'h4500_4500_4500_4500, 5'h00};

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_rm = '0; req_mask = '0; req_a = '0; req_b = '0; req_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_fma_valid", fma_valid, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, 64'h0);
        chk("reset_rsp_fflags", rsp_fflags, 5'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_req(vecs[i].name, vecs[i].op, 3'd0, vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].c,
                    vecs[i].hold, vecs[i].exp_data, vecs[i].exp_ff);

        // Reset during the lane-2 issue cycle must abort without a response.
        req_op = 2'd0; req_rm = 3'd0; req_mask = 4'hF; req_valid = 1'b1;
        req_a = vecs[0].a; req_b = vecs[0].b; req_c = vecs[0].c;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_lane2_issue", fma_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_ready", req_ready, 1'b1);
        chk("abort_fma_valid", fma_valid, 1'b0);
        chk("abort_data_clear", rsp_data, 64'h0);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        chk("abort_no_rsp", saw, 1'b0);
        run_req("after_abort", 2'd0, 3'd0, 4'hF, vecs[0].a, vecs[0].b, 64'h4400_4400_4400_4400, 0,
                64'h4600_4600_4600_4600, 5'h00);

`ifdef TT_VFP_FMA_SEQ_COMPACT_EN
        run_req("compact_lane3", 2'd0, 3'd0, 4'h8, vecs[0].a, vecs[0].b, vecs[0].c, 0,
                64'h4500_4200_4200_4200, 5'h00);
`endif

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < NE; k++) begin
                a[k*16 +: 16] = rnd_fp16();
                b[k*16 +: 16] = rnd_fp16();
                c[k*16 +: 16] = rnd_fp16();
            end
            req_op = 2'($urandom); req_mask = 4'($urandom);
            r = ref_rsp(req_op, req_mask, a, b, c);
            run_req($sformatf("rand%0d", t), req_op, 3'($urandom), req_mask, a, b, c,
                    $urandom_range(0, 2), r[63:0], r[68:64]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
